// File: rtl/pong_ball_engine_if.sv
// Bundle between the game side (paddles, serve control) and the ball engine.
// Latency: none; plain wires, all engine outputs are registered inside the engine.
// Backpressure: none; frame_tick is a strobe and the engine never stalls it.
interface pong_ball_engine_if;
    // game -> engine
    logic       frame_tick;
    logic       serve_req;
    logic       score_clr;
    logic [9:0] paddle_one_y;
    logic [9:0] paddle_two_y;
    // engine -> game
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic [1:0] collided;
    logic [1:0] missed;
    logic [3:0] score_one;
    logic [3:0] score_two;
    logic [1:0] state;
    logic [2:0] speed;

    modport master (
        output frame_tick, serve_req, score_clr, paddle_one_y, paddle_two_y,
        input  ball_x, ball_y, collided, missed, score_one, score_two, state, speed
    );

    modport slave (
        input  frame_tick, serve_req, score_clr, paddle_one_y, paddle_two_y,
        output ball_x, ball_y, collided, missed, score_one, score_two, state, speed
    );
endinterface

// File: rtl/pong_ball_engine.sv
// Pong ball engine: position, direction, speed ramp, wall/paddle bounce, miss, serve and score.
// Latency: a frame_tick (or serve_req/score_clr) sampled in cycle N is reflected on outputs in N+1.
// Backpressure: none; every frame_tick is consumed. Optional paddle spin enabled by PONG_SPIN_EN.
module pong_ball_engine #(
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int BALL_SIZE    = 10,
    parameter int PADDLE_LEN   = 50,
    parameter int PADDLE_W     = 5,
    parameter int P1_X         = 30,
    parameter int P2_X         = 600,
    parameter int WALL_MARGIN  = 10,
    parameter int MISS_MARGIN  = 2,
    parameter int SPEED_INIT   = 2,
    parameter int SPEED_MAX    = 6,
    parameter int SERVE_FRAMES = 127
) (
    input  logic               clk50M,
    input  logic               reset_n,
    pong_ball_engine_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SERVE = 2'b01,
        ST_PLAY  = 2'b10,
        ST_MISS  = 2'b11
    } state_e;

    // Geometry, all in 11 bits so ball+speed or paddle+length never wraps.
    localparam logic [10:0] CX       = 11'(SCREEN_W / 2 - BALL_SIZE / 2);
    localparam logic [10:0] CY       = 11'(SCREEN_H / 2 - BALL_SIZE / 2);
    localparam logic [10:0] X_MAX    = 11'(SCREEN_W - BALL_SIZE);
    localparam logic [10:0] Y_MAX    = 11'(SCREEN_H - BALL_SIZE);
    localparam logic [10:0] BALL_EXT = 11'(BALL_SIZE - 1);
    localparam logic [10:0] PAD_EXT  = 11'(PADDLE_LEN - 1);
    localparam logic [10:0] P1_L     = 11'(P1_X);
    localparam logic [10:0] P1_R     = 11'(P1_X + PADDLE_W);
    localparam logic [10:0] P2_L     = 11'(P2_X);
    localparam logic [10:0] P2_R     = 11'(P2_X + PADDLE_W);
    localparam logic [10:0] WALL_TOP = 11'(WALL_MARGIN);
    localparam logic [10:0] WALL_BOT = 11'(SCREEN_H - WALL_MARGIN);
    localparam logic [10:0] MISS_L   = 11'(MISS_MARGIN);
    localparam logic [10:0] MISS_R   = 11'(SCREEN_W - MISS_MARGIN);
    localparam logic [2:0]  SPD_INIT = 3'(SPEED_INIT);
    localparam logic [2:0]  SPD_MAX  = 3'(SPEED_MAX);
    localparam logic [6:0]  TMR_LOAD = 7'(SERVE_FRAMES);
    localparam logic [3:0]  SCORE_TOP = 4'd9;
`ifdef PONG_SPIN_EN
    localparam logic signed [11:0] SPIN_LO = 12'(PADDLE_LEN / 4);
    localparam logic signed [11:0] SPIN_HI = 12'(3 * PADDLE_LEN / 4);
`endif

    // Direction encoding: dir_x 1 = right, dir_y 1 = down.
    state_e     state_q,     state_d;
    logic [9:0] ball_x_q,    ball_x_d;
    logic [9:0] ball_y_q,    ball_y_d;
    logic       dir_x_q,     dir_x_d;
    logic       dir_y_q,     dir_y_d;
    logic       serve_dir_q, serve_dir_d;
    logic [2:0] speed_q,     speed_d;
    logic [6:0] timer_q,     timer_d;
    logic [1:0] collided_q,  collided_d;
    logic [1:0] missed_q,    missed_d;
    logic [3:0] score_one_q, score_one_d;
    logic [3:0] score_two_q, score_two_d;

    // Current ball box and paddle spans, widened to 11 bits.
    logic [10:0] bx, by, bx_r, by_b;
    logic [10:0] py1, py1_b, py2, py2_b;

    assign bx    = {1'b0, ball_x_q};
    assign by    = {1'b0, ball_y_q};
    assign bx_r  = bx + BALL_EXT;
    assign by_b  = by + BALL_EXT;
    assign py1   = {1'b0, bus.paddle_one_y};
    assign py2   = {1'b0, bus.paddle_two_y};
    assign py1_b = py1 + PAD_EXT;
    assign py2_b = py2 + PAD_EXT;

    // Per-frame collision terms; only meaningful while playing.
    logic hit1, hit2, miss_l, miss_r;

    assign hit1 = !dir_x_q && (bx <= P1_R) && (bx_r >= P1_L) && (by_b >= py1) && (by <= py1_b);
    assign hit2 =  dir_x_q && (bx <= P2_R) && (bx_r >= P2_L) && (by_b >= py2) && (by <= py2_b);
    // A paddle hit always wins over a miss on the same frame.
    assign miss_l = !hit1 && !hit2 && !dir_x_q && (bx <= MISS_L);
    assign miss_r = !hit1 && !hit2 &&  dir_x_q && (bx_r >= MISS_R);

`ifdef PONG_SPIN_EN
    // Ball centre offset from the top of whichever paddle is being struck.
    logic signed [11:0] spin_c;
    assign spin_c = {1'b0, by} + 12'(BALL_SIZE / 2) - (hit2 ? {1'b0, py2} : {1'b0, py1});
`endif

    logic [10:0] spd11, nx, ny;

    // Next-state and next-output computation for the whole engine.
    always_comb begin
        state_d     = state_q;
        ball_x_d    = ball_x_q;
        ball_y_d    = ball_y_q;
        dir_x_d     = dir_x_q;
        dir_y_d     = dir_y_q;
        serve_dir_d = serve_dir_q;
        speed_d     = speed_q;
        timer_d     = timer_q;
        collided_d  = 2'b00;
        missed_d    = 2'b00;
        score_one_d = score_one_q;
        score_two_d = score_two_q;
        spd11       = '0;
        nx          = bx;
        ny          = by;

        case (state_q)
            ST_IDLE: begin
                ball_x_d = CX[9:0];
                ball_y_d = CY[9:0];
                if (bus.serve_req) begin
                    timer_d = TMR_LOAD;
                    state_d = ST_SERVE;
                end
            end

            ST_SERVE: begin
                ball_x_d = CX[9:0];
                ball_y_d = CY[9:0];
                if (bus.frame_tick) begin
                    if (timer_q == 7'd0) state_d = ST_PLAY;
                    else                 timer_d = timer_q - 7'd1;
                end
            end

            ST_PLAY: begin
                if (bus.frame_tick) begin
                    // Walls first; a paddle hit on the same frame still applies afterwards.
                    if (!dir_y_q && by <= WALL_TOP)      dir_y_d = 1'b1;
                    else if (dir_y_q && by_b >= WALL_BOT) dir_y_d = 1'b0;

                    if (hit1 || hit2) begin
                        dir_x_d    = hit1;
                        collided_d = {hit2, hit1};
                        speed_d    = (speed_q >= SPD_MAX) ? SPD_MAX : speed_q + 3'd1;
`ifdef PONG_SPIN_EN
                        if (spin_c < SPIN_LO)       dir_y_d = 1'b0;
                        else if (spin_c >= SPIN_HI) dir_y_d = 1'b1;
`endif
                    end

                    if (miss_l || miss_r) begin
                        // Ball stays where it was; the side that missed serves next.
                        missed_d    = {miss_r, miss_l};
                        serve_dir_d = miss_r;
                        timer_d     = TMR_LOAD;
                        state_d     = ST_MISS;
                        if (miss_l && score_two_q != SCORE_TOP) score_two_d = score_two_q + 4'd1;
                        if (miss_r && score_one_q != SCORE_TOP) score_one_d = score_one_q + 4'd1;
                    end else begin
                        // Move with the direction and speed just decided, clamped to screen.
                        spd11 = {8'd0, speed_d};
                        if (dir_x_d) nx = (bx + spd11 > X_MAX) ? X_MAX : bx + spd11;
                        else         nx = (bx < spd11) ? 11'd0 : bx - spd11;
                        if (dir_y_d) ny = (by + spd11 > Y_MAX) ? Y_MAX : by + spd11;
                        else         ny = (by < spd11) ? 11'd0 : by - spd11;
                        ball_x_d = nx[9:0];
                        ball_y_d = ny[9:0];
                    end
                end
            end

            ST_MISS: begin
                if (bus.frame_tick) begin
                    if (timer_q == 7'd0) begin
                        state_d  = ST_IDLE;
                        ball_x_d = CX[9:0];
                        ball_y_d = CY[9:0];
                        speed_d  = SPD_INIT;
                        dir_x_d  = serve_dir_q;
                        dir_y_d  = 1'b1;
                    end else begin
                        timer_d = timer_q - 7'd1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Clear beats any increment decided above.
        if (bus.score_clr) begin
            score_one_d = 4'd0;
            score_two_d = 4'd0;
        end
    end

    // State register; reset lands the ball at centre, serving right.
    always_ff @(posedge clk50M or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            ball_x_q    <= CX[9:0];
            ball_y_q    <= CY[9:0];
            dir_x_q     <= 1'b1;
            dir_y_q     <= 1'b1;
            serve_dir_q <= 1'b1;
            speed_q     <= SPD_INIT;
            timer_q     <= 7'd0;
            collided_q  <= 2'b00;
            missed_q    <= 2'b00;
            score_one_q <= 4'd0;
            score_two_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
            serve_dir_q <= serve_dir_d;
            speed_q     <= speed_d;
            timer_q     <= timer_d;
            collided_q  <= collided_d;
            missed_q    <= missed_d;
            score_one_q <= score_one_d;
            score_two_q <= score_two_d;
        end
    end

    assign bus.ball_x    = ball_x_q;
    assign bus.ball_y    = ball_y_q;
    assign bus.collided  = collided_q;
    assign bus.missed    = missed_q;
    assign bus.score_one = score_one_q;
    assign bus.score_two = score_two_q;
    assign bus.state     = state_q;
    assign bus.speed     = speed_q;

    // A side can never both hit and miss on the same frame; speed stays in its range.
    a_hit_miss_exclusive: assert property (@(posedge clk50M) disable iff (!reset_n)
        (collided_q & missed_q) == 2'b00);
    a_speed_range: assert property (@(posedge clk50M) disable iff (!reset_n)
        (speed_q >= SPD_INIT) && (speed_q <= SPD_MAX));
    a_score_range: assert property (@(posedge clk50M) disable iff (!reset_n)
        (score_one_q <= SCORE_TOP) && (score_two_q <= SCORE_TOP));

endmodule

// File: tb/tb_pong_ball_engine.sv
// Randomised game play against a frame-level reference model of the pong rules.
// Latency: model predicts outputs one cycle after each set of inputs is applied.
// Backpressure: none; frame_tick is issued freely, including back-to-back.
module tb_pong_ball_engine;

    localparam int SCREEN_W = 640, SCREEN_H = 480, BALL_SIZE = 10;
    localparam int PADDLE_LEN = 50, PADDLE_W = 5, P1_X = 30, P2_X = 600;
    localparam int WALL_MARGIN = 10, MISS_MARGIN = 2;
    localparam int SPEED_INIT = 2, SPEED_MAX = 6, SERVE_FRAMES = 127;
    localparam int CX = SCREEN_W / 2 - BALL_SIZE / 2;
    localparam int CY = SCREEN_H / 2 - BALL_SIZE / 2;
    localparam int MAX_CYCLES = 60000;

    // Phases of a point, in the order a rally goes through them.
    localparam int PH_IDLE = 0, PH_SERVE = 1, PH_PLAY = 2, PH_MISS = 3;

    typedef struct packed {
        int phase;
        int x;
        int y;
        bit going_right;
        bit going_down;
        bit serve_right;
        int spd;
        int wait_frames;
        int hit_bits;
        int miss_bits;
        int p1;
        int p2;
    } game_t;

    logic clk50M;
    logic reset_n;

    pong_ball_engine_if bus();

    pong_ball_engine dut (
        .clk50M  (clk50M),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk50M = 1'b0;
    always #10 clk50M = ~clk50M;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic game_t game_reset();
        game_t g;
        g.phase = PH_IDLE; g.x = CX; g.y = CY;
        g.going_right = 1'b1; g.going_down = 1'b1; g.serve_right = 1'b1;
        g.spd = SPEED_INIT; g.wait_frames = 0;
        g.hit_bits = 0; g.miss_bits = 0; g.p1 = 0; g.p2 = 0;
        return g;
    endfunction

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    // What one clock does to the game, given the inputs sampled on that clock.
    function automatic game_t game_step(input game_t g, input bit tick, input bit sreq,
                                        input bit sclr, input int pad1, input int pad2);
        game_t n;
        int pad_top;
        bit struck;
        int c;
        n = g;
        n.hit_bits = 0;
        n.miss_bits = 0;
        struck = 1'b0;
        pad_top = 0;
        c = 0;
        if (g.phase == PH_IDLE) begin
            if (sreq) begin
                n.phase = PH_SERVE;
                n.wait_frames = SERVE_FRAMES;
            end
        end else if (g.phase == PH_SERVE && tick) begin
            if (g.wait_frames == 0) n.phase = PH_PLAY;
            else n.wait_frames = g.wait_frames - 1;
        end else if (g.phase == PH_PLAY && tick) begin
            if (!g.going_down && g.y <= WALL_MARGIN) n.going_down = 1'b1;
            else if (g.going_down && g.y + BALL_SIZE - 1 >= SCREEN_H - WALL_MARGIN) n.going_down = 1'b0;

            if (!g.going_right && g.x <= P1_X + PADDLE_W && g.x + BALL_SIZE - 1 >= P1_X &&
                g.y + BALL_SIZE - 1 >= pad1 && g.y <= pad1 + PADDLE_LEN - 1) begin
                struck = 1'b1; pad_top = pad1; n.going_right = 1'b1; n.hit_bits = 1;
            end else if (g.going_right && g.x <= P2_X + PADDLE_W && g.x + BALL_SIZE - 1 >= P2_X &&
                         g.y + BALL_SIZE - 1 >= pad2 && g.y <= pad2 + PADDLE_LEN - 1) begin
                struck = 1'b1; pad_top = pad2; n.going_right = 1'b0; n.hit_bits = 2;
            end

            if (struck) begin
                n.spd = (g.spd + 1 > SPEED_MAX) ? SPEED_MAX : g.spd + 1;
`ifdef PONG_SPIN_EN
                c = g.y + BALL_SIZE / 2 - pad_top;
                if (c < PADDLE_LEN / 4) n.going_down = 1'b0;
                else if (c >= 3 * PADDLE_LEN / 4) n.going_down = 1'b1;
`endif
            end

            if (!struck && !g.going_right && g.x <= MISS_MARGIN) begin
                n.miss_bits = 1; n.p2 = (g.p2 == 9) ? 9 : g.p2 + 1;
                n.serve_right = 1'b0; n.phase = PH_MISS; n.wait_frames = SERVE_FRAMES;
            end else if (!struck && g.going_right && g.x + BALL_SIZE - 1 >= SCREEN_W - MISS_MARGIN) begin
                n.miss_bits = 2; n.p1 = (g.p1 == 9) ? 9 : g.p1 + 1;
                n.serve_right = 1'b1; n.phase = PH_MISS; n.wait_frames = SERVE_FRAMES;
            end else begin
                n.x = clamp(g.x + (n.going_right ? n.spd : -n.spd), 0, SCREEN_W - BALL_SIZE);
                n.y = clamp(g.y + (n.going_down  ? n.spd : -n.spd), 0, SCREEN_H - BALL_SIZE);
            end
        end else if (g.phase == PH_MISS && tick) begin
            if (g.wait_frames == 0) begin
                n.phase = PH_IDLE; n.x = CX; n.y = CY; n.spd = SPEED_INIT;
                n.going_right = g.serve_right; n.going_down = 1'b1;
            end else begin
                n.wait_frames = g.wait_frames - 1;
            end
        end
        if (sclr) begin
            n.p1 = 0;
            n.p2 = 0;
        end
        return n;
    endfunction

    task automatic compare_all(input string where, input game_t g);
        check_eq({where, ".ball_x"},    int'(bus.ball_x),    g.x);
        check_eq({where, ".ball_y"},    int'(bus.ball_y),    g.y);
        check_eq({where, ".state"},     int'(bus.state),     g.phase);
        check_eq({where, ".speed"},     int'(bus.speed),     g.spd);
        check_eq({where, ".collided"},  int'(bus.collided),  g.hit_bits);
        check_eq({where, ".missed"},    int'(bus.missed),    g.miss_bits);
        check_eq({where, ".score_one"}, int'(bus.score_one), g.p1);
        check_eq({where, ".score_two"}, int'(bus.score_two), g.p2);
    endtask

    initial begin
        game_t m, trial;
        int  rst_hold, rst_done, frames, pad_off;
        bit  will_hit, prev_right, tick, sreq, sclr;
        int  pad;

        reset_n = 1'b0;
        bus.frame_tick = 1'b0; bus.serve_req = 1'b0; bus.score_clr = 1'b0;
        bus.paddle_one_y = '0; bus.paddle_two_y = '0;
        m = game_reset();
        rst_hold = 0; rst_done = 0; frames = 0;
        will_hit = 1'b1; pad_off = 10; prev_right = 1'b1;

        @(negedge clk50M);
        compare_all("reset", m);
        @(negedge clk50M);
        compare_all("reset", m);
        reset_n = 1'b1;

        for (int cyc = 0; cyc < MAX_CYCLES && n_fail < 40; cyc++) begin
            @(negedge clk50M);
            compare_all("play", m);

            // Pull reset while a pulse is showing; it must drop immediately.
            if (reset_n && rst_done < 2 && frames > 9000 * (rst_done + 1) &&
                (m.hit_bits != 0 || m.miss_bits != 0)) begin
                reset_n = 1'b0;
                m = game_reset();
                #1;
                compare_all("async_rst", m);
                rst_hold = 3;
                rst_done++;
            end else if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) reset_n = 1'b1;
            end

            // Re-decide hit or miss each time the ball turns or a point starts.
            if (m.phase != PH_PLAY || m.going_right != prev_right) begin
                will_hit = ($urandom_range(99) < 65);
                pad_off  = $urandom_range(PADDLE_LEN - 1);
            end
            prev_right = m.going_right;
            if (will_hit) pad = (m.y >= pad_off) ? m.y - pad_off : 0;
            else          pad = (m.y >= 60) ? 0 : 200;

            tick = ($urandom_range(99) < 70);
            sreq = ($urandom_range(3) == 0);
            trial = game_step(m, tick, sreq, 1'b0, pad, pad);
            if ((trial.miss_bits == 1 && m.p2 == 9) || (trial.miss_bits == 2 && m.p1 == 9))
                sclr = ($urandom_range(1) == 0);
            else
                sclr = ($urandom_range(4999) == 0);

            bus.frame_tick   = tick;
            bus.serve_req    = sreq;
            bus.score_clr    = sclr;
            bus.paddle_one_y = 10'(pad);
            bus.paddle_two_y = 10'(pad);
            if (tick) frames++;
            if (reset_n) m = game_step(m, tick, sreq, sclr, pad, pad);
        end

        @(negedge clk50M);
        compare_all("final", m);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
